// File: rtl/rf_ctrl_pkg.sv
// Shared types and constants for the register-file write-back control slice.
package rf_ctrl_pkg;
  localparam int NUM_REGS       = 32;
  localparam int DATA_W_DEFAULT = 32;

  typedef logic [4:0] reg_addr_t;
  localparam reg_addr_t REG_ZERO = 5'd0;

  typedef logic [DATA_W_DEFAULT-1:0] data_t;

  typedef struct packed {
    reg_addr_t rd;
    data_t     data;
  } wb_req_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per architectural register.
module rf_scoreboard
  import rf_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      issue_en,
  input  reg_addr_t issue_rd,
  input  logic      flush,
  input  logic      clr_en,
  input  reg_addr_t clr_rd,
  input  reg_addr_t rs1,
  input  reg_addr_t rs2,
  output logic      rs1_busy,
  output logic      rs2_busy,
  output logic      any_busy
);
  localparam logic [NUM_REGS-1:0] ZERO_MASK = ~(NUM_REGS'(1));

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_en && issue_rd != REG_ZERO) set_mask[issue_rd] = 1'b1;
    if (clr_en) clr_mask[clr_rd] = 1'b1;
  end

  // Set is applied after clear so a same-edge re-issue keeps the bit; flush overrides both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      busy <= ((busy & ~clr_mask) | set_mask) & ZERO_MASK;
    end
  end

  assign rs1_busy = busy[rs1];
  assign rs2_busy = busy[rs2];
  assign any_busy = |busy;
endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-source (ALU/LSU) register-file write-back arbiter with busy scoreboard.
// Optional decode bypass of the write-back stage when RF_WB_BYPASS_EN is defined.
module rf_wb_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [4:0]        alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [4:0]        lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              lsu_ready,
  input  logic              issue_en,
  input  logic [4:0]        issue_rd,
  input  logic              flush,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              rf_we,
  output logic [4:0]        rf_a3,
  output logic [DATA_W-1:0] rf_wd,
  output logic              idle
`ifdef RF_WB_BYPASS_EN
  ,
  output logic              rs1_fwd,
  output logic              rs2_fwd,
  output logic [DATA_W-1:0] rs1_fwd_data,
  output logic [DATA_W-1:0] rs2_fwd_data
`endif
);
  // Handshake: a request transfers on the rising edge where valid && ready;
  // ready depends on valid only, is never high without its own valid, and
  // at most one ready is high per cycle. Both readies are held low in reset.
  logic last_lsu;
  logic grant_alu;
  logic grant_lsu;
  logic sb_rs1_busy;
  logic sb_rs2_busy;
  logic any_busy;

  assign grant_alu = rst_n && alu_valid && (!lsu_valid || last_lsu);
  assign grant_lsu = rst_n && lsu_valid && !grant_alu;
  assign alu_ready = grant_alu;
  assign lsu_ready = grant_lsu;

  // Writes to x0 complete the handshake but never raise rf_we.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_lsu <= 1'b1;
      rf_we    <= 1'b0;
      rf_a3    <= '0;
      rf_wd    <= '0;
    end else begin
      rf_we <= 1'b0;
      if (grant_alu) begin
        last_lsu <= 1'b0;
        rf_we    <= (alu_rd != REG_ZERO);
        rf_a3    <= alu_rd;
        rf_wd    <= alu_data;
      end else if (grant_lsu) begin
        last_lsu <= 1'b1;
        rf_we    <= (lsu_rd != REG_ZERO);
        rf_a3    <= lsu_rd;
        rf_wd    <= lsu_data;
      end
    end
  end

  rf_scoreboard u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .issue_en (issue_en),
    .issue_rd (issue_rd),
    .flush    (flush),
    .clr_en   (rf_we),
    .clr_rd   (rf_a3),
    .rs1      (rs1),
    .rs2      (rs2),
    .rs1_busy (sb_rs1_busy),
    .rs2_busy (sb_rs2_busy),
    .any_busy (any_busy)
  );

`ifdef RF_WB_BYPASS_EN
  assign rs1_fwd      = rf_we && (rf_a3 == rs1) && (rs1 != REG_ZERO);
  assign rs2_fwd      = rf_we && (rf_a3 == rs2) && (rs2 != REG_ZERO);
  assign rs1_fwd_data = rf_wd;
  assign rs2_fwd_data = rf_wd;
  assign rs1_busy     = sb_rs1_busy && !rs1_fwd;
  assign rs2_busy     = sb_rs2_busy && !rs2_fwd;
`else
  assign rs1_busy     = sb_rs1_busy;
  assign rs2_busy     = sb_rs2_busy;
`endif

  assign idle = !any_busy && !rf_we;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: cycle model compared every cycle plus directed literal checks.
module tb_rf_wb_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         alu_valid = 1'b0;
  logic [4:0]   alu_rd = '0;
  logic [W-1:0] alu_data = '0;
  logic         alu_ready;
  logic         lsu_valid = 1'b0;
  logic [4:0]   lsu_rd = '0;
  logic [W-1:0] lsu_data = '0;
  logic         lsu_ready;
  logic         issue_en = 1'b0;
  logic [4:0]   issue_rd = '0;
  logic         flush = 1'b0;
  logic [4:0]   rs1 = '0;
  logic [4:0]   rs2 = '0;
  logic         rs1_busy;
  logic         rs2_busy;
  logic         rf_we;
  logic [4:0]   rf_a3;
  logic [W-1:0] rf_wd;
  logic         idle;
`ifdef RF_WB_BYPASS_EN
  logic         rs1_fwd;
  logic         rs2_fwd;
  logic [W-1:0] rs1_fwd_data;
  logic [W-1:0] rs2_fwd_data;
`endif

  int errors = 0;
  int checks = 0;

  rf_wb_arbiter #(.DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .idle(idle)
`ifdef RF_WB_BYPASS_EN
    , .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd),
    .rs1_fwd_data(rs1_fwd_data), .rs2_fwd_data(rs2_fwd_data)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: set of pending registers, last winner, write-back slot
  bit         m_busy[32];
  bit         m_last_lsu;
  bit         m_we;
  bit [4:0]   m_a3;
  bit [W-1:0] m_wd;
  bit         n_busy[32];
  bit         n_last_lsu;
  bit         n_we;
  bit [4:0]   n_a3;
  bit [W-1:0] n_wd;

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_last_lsu = 1'b1;
    m_we = 1'b0;
    m_a3 = '0;
    m_wd = '0;
  endtask

  function automatic bit exp_rs_busy(input bit [4:0] rs);
    bit fwd;
    fwd = m_we && (m_a3 == rs) && (rs != 0);
`ifdef RF_WB_BYPASS_EN
    return m_busy[rs] && !fwd;
`else
    return m_busy[rs] && (fwd || !fwd);
`endif
  endfunction

  // compare process: checks every cycle, then computes the state after the next edge
  always @(negedge clk) begin
    bit e_alu, e_lsu, any;
    if (!rst_n) model_reset();
    e_alu = rst_n && alu_valid && (!lsu_valid || m_last_lsu);
    e_lsu = rst_n && lsu_valid && !e_alu;
    any = 1'b0;
    foreach (m_busy[i]) any |= m_busy[i];
    chk("alu_ready", alu_ready, e_alu);
    chk("lsu_ready", lsu_ready, e_lsu);
    chk("rf_we", rf_we, m_we);
    if (m_we || !rst_n) begin
      chk("rf_a3", rf_a3, m_a3);
      chk("rf_wd", rf_wd, m_wd);
    end
    chk("idle", idle, !any && !m_we);
    chk("rs1_busy", rs1_busy, exp_rs_busy(rs1));
    chk("rs2_busy", rs2_busy, exp_rs_busy(rs2));
`ifdef RF_WB_BYPASS_EN
    chk("rs1_fwd", rs1_fwd, m_we && m_a3 == rs1 && rs1 != 0);
    chk("rs2_fwd", rs2_fwd, m_we && m_a3 == rs2 && rs2 != 0);
    if (m_we && m_a3 == rs1 && rs1 != 0) chk("rs1_fwd_data", rs1_fwd_data, m_wd);
    if (m_we && m_a3 == rs2 && rs2 != 0) chk("rs2_fwd_data", rs2_fwd_data, m_wd);
`endif
    n_busy = m_busy;
    if (m_we) n_busy[m_a3] = 1'b0;
    if (flush) foreach (n_busy[i]) n_busy[i] = 1'b0;
    else if (issue_en && issue_rd != 0) n_busy[issue_rd] = 1'b1;
    n_last_lsu = m_last_lsu;
    n_we = 1'b0;
    n_a3 = m_a3;
    n_wd = m_wd;
    if (e_alu) begin
      n_last_lsu = 1'b0; n_we = (alu_rd != 0); n_a3 = alu_rd; n_wd = alu_data;
    end else if (e_lsu) begin
      n_last_lsu = 1'b1; n_we = (lsu_rd != 0); n_a3 = lsu_rd; n_wd = lsu_data;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else begin
      m_busy = n_busy; m_last_lsu = n_last_lsu; m_we = n_we; m_a3 = n_a3; m_wd = n_wd;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    alu_valid = 0; lsu_valid = 0; issue_en = 0; flush = 0;
  endtask

  initial begin
    bit [4:0]   t_ard[8] = '{5'd1, 5'd2, 5'd0, 5'd6, 5'd1, 5'd8, 5'd2, 5'd0};
    bit [4:0]   t_lrd[8] = '{5'd2, 5'd1, 5'd3, 5'd0, 5'd6, 5'd8, 5'd31, 5'd4};
    bit [3:0]   t_ctl[8] = '{4'b0111, 4'b1011, 4'b1100, 4'b0001, 4'b1111, 4'b0111, 4'b1110, 4'b0011};
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_rf_a3", rf_a3, 5'd0);
    chk("rst_rf_wd", rf_wd, 32'd0);
    chk("rst_idle", idle, 1'b1);

    // both sources held: ALU wins first tie, then alternates
    step();
    rst_n = 1; alu_valid = 1; lsu_valid = 1;
    for (int i = 0; i < 4; i++) begin
      alu_rd = 5'(10 + i); alu_data = 32'hA000 + i;
      lsu_rd = 5'(20 + i); lsu_data = 32'hB000 + i;
      @(negedge clk);
      chk("rr_alu", alu_ready, (i % 2) == 0);
      chk("rr_lsu", lsu_ready, (i % 2) == 1);
      step();
    end
    clear_inputs();
    step(); step();

    // x0 write: handshake only
    lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h1234;
    @(negedge clk);
    chk("x0_lsu_ready", lsu_ready, 1'b1);
    step();
    clear_inputs();
    @(negedge clk);
    chk("x0_rf_we", rf_we, 1'b0);
    chk("x0_idle", idle, 1'b1);

    // issue rd=5, ALU writes it back, busy until the write-back cycle ends
    step();
    issue_en = 1; issue_rd = 5; rs1 = 5;
    step();
    issue_en = 0; alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("wb_alu_ready", alu_ready, 1'b1);
    chk("wb_rs1_busy_pre", rs1_busy, 1'b1);
    step();
    clear_inputs();
    @(negedge clk);
    chk("wb_rf_we", rf_we, 1'b1);
    chk("wb_rf_a3", rf_a3, 5'd5);
    chk("wb_rf_wd", rf_wd, 32'hDEADBEEF);
`ifdef RF_WB_BYPASS_EN
    chk("wb_rs1_busy_wb", rs1_busy, 1'b0);
`else
    chk("wb_rs1_busy_wb", rs1_busy, 1'b1);
`endif
    step();
    @(negedge clk);
    chk("wb_rs1_busy_post", rs1_busy, 1'b0);

    // same-edge clear and re-issue of r7: set wins
    step();
    issue_en = 1; issue_rd = 7; rs1 = 7;
    step();
    issue_en = 0; alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
    step();
    alu_valid = 0; issue_en = 1; issue_rd = 7;
    step();
    issue_en = 0;
    @(negedge clk);
    chk("setwins_busy7", rs1_busy, 1'b1);

    // flush with a concurrent issue and an in-flight write
    step();
    issue_en = 1; issue_rd = 3;
    step();
    issue_rd = 4; lsu_valid = 1; lsu_rd = 3; lsu_data = 32'h3333;
    step();
    lsu_valid = 0; flush = 1; issue_en = 1; issue_rd = 9; rs1 = 3; rs2 = 4;
    step();
    clear_inputs();
    @(negedge clk);
    chk("flush_rs1", rs1_busy, 1'b0);
    chk("flush_rs2", rs2_busy, 1'b0);
    chk("flush_idle", idle, 1'b1);
    rs1 = 9;
    step();
    @(negedge clk);
    chk("flush_ignored_issue", rs1_busy, 1'b0);

    // mixed table: ctl = {alu_valid, lsu_valid, issue_en, flush-less issue select}
    for (int i = 0; i < 8; i++) begin
      step();
      alu_valid = t_ctl[i][3]; alu_rd = t_ard[i]; alu_data = 32'hC0DE0000 + i;
      lsu_valid = t_ctl[i][2]; lsu_rd = t_lrd[i]; lsu_data = 32'hFACE0000 + i;
      issue_en = t_ctl[i][1]; issue_rd = t_ctl[i][0] ? t_lrd[i] : t_ard[i];
      rs1 = t_ard[i]; rs2 = t_lrd[i];
    end
    step();
    clear_inputs();
    repeat (3) step();

    // reset pulse in the middle of a burst
    alu_valid = 1; lsu_valid = 1; alu_rd = 13; lsu_rd = 14;
    alu_data = 32'h1313; lsu_data = 32'h1414;
    issue_en = 1; issue_rd = 13;
    step();
    step();
    rst_n = 0;
    #1;
    chk("rstmid_rf_we", rf_we, 1'b0);
    chk("rstmid_idle", idle, 1'b1);
    step();
    rst_n = 1; issue_en = 0;
    @(negedge clk);
    chk("rstmid_alu_first", alu_ready, 1'b1);
    step(); step();
    clear_inputs();
    repeat (2) step();

`ifdef RF_WB_BYPASS_EN
    issue_en = 1; issue_rd = 12;
    step();
    issue_en = 0; lsu_valid = 1; lsu_rd = 12; lsu_data = 32'h55AA;
    step();
    lsu_valid = 0; rs2 = 12;
    @(negedge clk);
    chk("byp_fwd", rs2_fwd, 1'b1);
    chk("byp_data", rs2_fwd_data, 32'h55AA);
    chk("byp_busy", rs2_busy, 1'b0);
    step();
`endif

    repeat (2) step();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
